// File: rtl/fixed_mul_seq.sv
// Sequential fixed-point multiplier: (a_int + a_frac/10000) * b, result in the same
// integer / 1e-4 fraction format, via 16-cycle shift-add then 16-cycle divide by 10000.
module fixed_mul_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a_int,
    input  logic [15:0] a_frac,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] p_int,
    output logic [15:0] p_frac,
    output logic        ovf,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] op_a;
    logic [13:0] op_f;
    logic [15:0] op_b;
    logic        err_cap;
    logic [31:0] acc_i;
    logic [29:0] acc_f;
    logic [14:0] rem;
    logic [15:0] quo;

    logic [31:0] i_next;
    logic [29:0] f_next;
    logic [15:0] trial;
    logic        trial_ge;
    logic [14:0] rem_next;
    logic [32:0] i_sum;

    always_comb begin
        i_next   = {acc_i[30:0], 1'b0} + (op_b[15] ? {16'd0, op_a} : 32'd0);
        f_next   = {acc_f[28:0], 1'b0} + (op_b[15] ? {16'd0, op_f} : 30'd0);
        // acc_f is left-aligned during DIV so its MSB feeds the next dividend bit
        trial    = {rem, acc_f[29]};
        trial_ge = (trial >= 16'd10000);
        rem_next = trial_ge ? (trial[14:0] - 15'd10000) : trial[14:0];
        i_sum    = {1'b0, acc_i} + {17'd0, quo};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            op_a    <= '0;
            op_f    <= '0;
            op_b    <= '0;
            err_cap <= 1'b0;
            acc_i   <= '0;
            acc_f   <= '0;
            rem     <= '0;
            quo     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            p_int   <= '0;
            p_frac  <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a <= a_int;
                        op_b <= b;
                        if (a_frac > 16'd9999) begin
                            op_f    <= 14'd9999;
                            err_cap <= 1'b1;
                        end else begin
                            op_f    <= a_frac[13:0];
                            err_cap <= 1'b0;
                        end
                        acc_i <= '0;
                        acc_f <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= MUL;
                    end
                end
                MUL: begin
                    acc_i <= i_next;
                    op_b  <= {op_b[14:0], 1'b0};
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        // F < 10000*2^16, so the top 14 bits already sit below the divisor
                        rem   <= {1'b0, f_next[29:16]};
                        acc_f <= {f_next[15:0], 14'd0};
                        quo   <= '0;
                        state <= DIV;
                    end else begin
                        acc_f <= f_next;
                    end
                end
                DIV: begin
                    rem   <= rem_next;
                    quo   <= {quo[14:0], trial_ge};
                    acc_f <= {acc_f[28:0], 1'b0};
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    p_int  <= i_sum[15:0];
                    p_frac <= {1'b0, rem};
                    ovf    <= |i_sum[32:16];
                    err    <= err_cap;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_mul_seq.sv
// Self-checking bench for fixed_mul_seq: directed corner cases, handshake, reset abort
// and randomized operands compared against an exact-arithmetic reference.
module tb_fixed_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a_int;
    logic [15:0] a_frac;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] p_int;
    logic [15:0] p_frac;
    logic        ovf;
    logic        err;

    int passed = 0;
    int total  = 0;

    fixed_mul_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_int  (a_int),
        .a_frac (a_frac),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .p_int  (p_int),
        .p_frac (p_frac),
        .ovf    (ovf),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Whole value scaled by 10000, multiplied exactly, then split back apart
    task automatic model(input logic [15:0] ai, input logic [15:0] af, input logic [15:0] bb,
                         output logic [15:0] ei, output logic [15:0] ef,
                         output logic eo, output logic ee);
        longint unsigned fa, tot, ip, fp;
        ee  = (af > 16'd9999);
        fa  = ee ? 64'd9999 : longint'(af);
        tot = (longint'(ai) * 64'd10000 + fa) * longint'(bb);
        ip  = tot / 64'd10000;
        fp  = tot % 64'd10000;
        ei  = ip[15:0];
        ef  = fp[15:0];
        eo  = (ip >= 64'd65536);
    endtask

    task automatic do_op(input logic [15:0] ai, input logic [15:0] af, input logic [15:0] bb,
                         input int glitch, input string tag);
        logic [15:0] ei, ef, h_int, h_frac;
        logic        eo, ee, h_ovf, h_err;
        int          n;
        bit          seen, stable;
        model(ai, af, bb, ei, ef, eo, ee);
        @(negedge clk);
        a_int = ai; a_frac = af; b = bb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        h_int = p_int; h_frac = p_frac; h_ovf = ovf; h_err = err;
        a_int = 16'($urandom); a_frac = 16'($urandom); b = 16'($urandom);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        n = 0; seen = 0; stable = 1;
        while (!seen && n < 60) begin
            start = (n == glitch);
            @(posedge clk); #1;
            n++;
            if (done) seen = 1;
            else if (p_int !== h_int || p_frac !== h_frac || ovf !== h_ovf || err !== h_err)
                stable = 0;
        end
        start = 1'b0;
        chk({tag, "_latency"}, n, 33);
        chk({tag, "_int"}, {16'd0, p_int}, {16'd0, ei});
        chk({tag, "_frac"}, {16'd0, p_frac}, {16'd0, ef});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        chk({tag, "_err"}, {31'd0, err}, {31'd0, ee});
        chk({tag, "_hold"}, {31'd0, stable}, 32'd1);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [15:0] ei, ef, h_int, h_frac;
        logic        eo, ee;
        int          n, dcount;
        bit          stable;

        rst_n = 1'b0; start = 1'b0; a_int = '0; a_frac = '0; b = '0;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_int", {16'd0, p_int}, 32'd0);
        chk("rst_frac", {16'd0, p_frac}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        do_op(16'd3, 16'd1428, 16'd7, -1, "div22_7");
        chk("div22_7_const_int", {16'd0, p_int}, 32'd21);
        chk("div22_7_const_frac", {16'd0, p_frac}, 32'd9996);
        do_op(16'd1, 16'd5000, 16'd3, -1, "carry1");
        do_op(16'd3, 16'd1416, 16'd2, -1, "carry2");
        do_op(16'd0, 16'd0, 16'd5, -1, "zero_a");
        do_op(16'd65535, 16'd9999, 16'd2, -1, "ovf_max");
        do_op(16'd0, 16'd9999, 16'd65535, -1, "frac_max");
        do_op(16'd1234, 16'd5678, 16'd0, -1, "b_zero");
        do_op(16'd0, 16'd12000, 16'd1, -1, "illegal");
        do_op(16'd2, 16'd2500, 16'd4, -1, "err_clear");
        do_op(16'd7, 16'd3333, 16'd3, 5, "glitch_mul");

        // back-to-back: start held high through the first done
        @(negedge clk);
        a_int = 16'd1; a_frac = 16'd5000; b = 16'd3; start = 1'b1;
        @(posedge clk); #1;
        a_int = 16'd3; a_frac = 16'd1416; b = 16'd2;
        n = 0;
        while (!done && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_lat1", n, 33);
        model(16'd1, 16'd5000, 16'd3, ei, ef, eo, ee);
        chk("b2b_int1", {16'd0, p_int}, {16'd0, ei});
        chk("b2b_frac1", {16'd0, p_frac}, {16'd0, ef});
        h_int = p_int; h_frac = p_frac;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy2", {31'd0, busy}, 32'd1);
        n = 1; stable = 1;
        while (!done && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (!done && (p_int !== h_int || p_frac !== h_frac)) stable = 0;
        end
        chk("b2b_spacing", n, 34);
        chk("b2b_hold", {31'd0, stable}, 32'd1);
        model(16'd3, 16'd1416, 16'd2, ei, ef, eo, ee);
        chk("b2b_int2", {16'd0, p_int}, {16'd0, ei});
        chk("b2b_frac2", {16'd0, p_frac}, {16'd0, ef});

        // prime nonzero outputs, then abort an operation mid-DIV
        do_op(16'd65535, 16'd9999, 16'd2, -1, "pre_rst");
        @(negedge clk);
        a_int = 16'd100; a_frac = 16'd100; b = 16'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_int", {16'd0, p_int}, 32'd0);
        chk("arst_frac", {16'd0, p_frac}, 32'd0);
        chk("arst_ovf", {31'd0, ovf}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("arst_no_done", dcount, 0);
        do_op(16'd3, 16'd1428, 16'd7, -1, "post_rst");

        for (int i = 0; i < 8; i++) begin
            do_op(16'($urandom), 16'($urandom_range(0, 10500)), 16'($urandom), -1, "rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
